msrv32_dmem_ctrl: RTL

Data-memory access controller for the MSRV32 core. Sits between the execute-stage address adder and the load unit. It accepts one load or store request at a time from the pipeline and runs it as an AHB-Lite style address/data phase with wait states. It then hands registered read data, byte offset, size, signedness and bus error status to the load unit, and stalls the pipeline until the access completes.

---
 rtl/msrv32_pkg.sv | 33 +++
 rtl/msrv32_dmem_align.sv | 26 ++
 rtl/msrv32_dmem_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the MSRV32 data-memory path: access sizes, controller
// states and the byte-lane / store-replication helpers.
package msrv32_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } dmem_state_e;

  // Size 2'b11 falls into the word case on purpose.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << offset;
      SIZE_HALF: lane_mask = 4'b0011 << {offset[1], 1'b0};
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: replicate = {4{data[7:0]}};
      SIZE_HALF: replicate = {2{data[15:0]}};
      default:   replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_dmem_align.sv
// Combinational request decode: misalignment check, write strobes (zero for
// loads) and store data replicated across the byte lanes.
module msrv32_dmem_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        we,
  input  logic [31:0] wdata_raw,
  output logic        misaligned,
  output logic [3:0]  mask,
  output logic [31:0] wdata
);

  always_comb begin
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = offset[0];
      default:   misaligned = |offset;
    endcase
  end

  assign mask  = we ? lane_mask(size, offset) : 4'b0000;
  assign wdata = replicate(size, wdata_raw);

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// Data-memory access controller: one load/store at a time over an AHB-Lite style
// address/data phase. Optional data-phase timeout under MSRV32_DMEM_TIMEOUT_EN.
module msrv32_dmem_ctrl
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [31:0] iadder_in,
  input  logic [1:0]  mem_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] rs2_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dmtrans_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  input  logic        ms_riscv32_mp_hready_in,
  input  logic        ms_riscv32_mp_hresp_in,
  input  logic [31:0] ms_riscv32_mp_dmrdata_in,
  output logic [31:0] lu_dmdata_out,
  output logic [1:0]  lu_iadder_1_to_0_out,
  output logic [1:0]  lu_load_size_out,
  output logic        lu_load_unsigned_out,
  output logic        lu_ahb_resp_out,
  output logic        lu_valid_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic [1:0]  dbg_state_out
);

  // Handshake: the pipeline raises mem_req_in and must hold it and its operands
  // stable while stall_out=1; the access is finished in the cycle lu_valid_out=1.
  // Bus side: a phase advances only on a cycle with hready=1.

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  dmem_state_e state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;

  logic        req_misaligned;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        done;
  logic        done_err;

  msrv32_dmem_align u_align (
    .offset     (iadder_in[1:0]),
    .size       (mem_size_in),
    .we         (mem_we_in),
    .wdata_raw  (rs2_in),
    .misaligned (req_misaligned),
    .mask       (req_mask),
    .wdata      (req_wdata)
  );

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_comb begin
    done     = 1'b0;
    done_err = 1'b0;
    if (state == ST_DATA && ms_riscv32_mp_hready_in) begin
      done     = 1'b1;
      done_err = ms_riscv32_mp_hresp_in;
    end else if (state == ST_ERR && ms_riscv32_mp_hready_in) begin
      done     = 1'b1;
      done_err = 1'b1;
    end
`ifdef MSRV32_DMEM_TIMEOUT_EN
    else if (state == ST_DATA && !ms_riscv32_mp_hresp_in && tmo_cnt == TMO_LAST) begin
      done     = 1'b1;
      done_err = 1'b1;
    end
`endif
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                <= ST_IDLE;
      addr_q               <= '0;
      wdata_q              <= '0;
      mask_q               <= '0;
      size_q               <= '0;
      we_q                 <= 1'b0;
      uns_q                <= 1'b0;
      lu_dmdata_out        <= '0;
      lu_iadder_1_to_0_out <= '0;
      lu_load_size_out     <= '0;
      lu_load_unsigned_out <= 1'b0;
      lu_ahb_resp_out      <= 1'b0;
      lu_valid_out         <= 1'b0;
      misaligned_out       <= 1'b0;
    end else begin
      lu_valid_out   <= done;
      misaligned_out <= 1'b0;
      if (done) begin
        lu_ahb_resp_out      <= done_err;
        lu_iadder_1_to_0_out <= addr_q[1:0];
        lu_load_size_out     <= size_q;
        lu_load_unsigned_out <= uns_q;
        if (!we_q && !done_err) lu_dmdata_out <= ms_riscv32_mp_dmrdata_in;
      end
      case (state)
        ST_IDLE: begin
          if (mem_req_in) begin
            if (req_misaligned) begin
              misaligned_out <= 1'b1;
            end else begin
              addr_q  <= iadder_in;
              wdata_q <= req_wdata;
              mask_q  <= req_mask;
              size_q  <= mem_size_in;
              we_q    <= mem_we_in;
              uns_q   <= load_unsigned_in;
              state   <= ST_ADDR;
            end
          end
        end
        ST_ADDR: if (ms_riscv32_mp_hready_in) state <= ST_DATA;
        ST_DATA: begin
          if (done) state <= ST_IDLE;
          else if (ms_riscv32_mp_hresp_in) state <= ST_ERR;
        end
        ST_ERR:  if (ms_riscv32_mp_hready_in) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MSRV32_DMEM_TIMEOUT_EN
  // Counts only uninterrupted wait cycles of the current data phase.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) tmo_cnt <= '0;
    else if (state == ST_DATA && !ms_riscv32_mp_hready_in && !ms_riscv32_mp_hresp_in)
      tmo_cnt <= tmo_cnt + 1'b1;
    else tmo_cnt <= '0;
  end
`endif

  assign ms_riscv32_mp_dmaddr_out    = {addr_q[31:2], 2'b00};
  assign ms_riscv32_mp_dmtrans_out   = (state == ST_ADDR);
  assign ms_riscv32_mp_dmwr_req_out  = (state == ST_ADDR) && we_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmdata_out    = wdata_q;
  assign dbg_state_out               = state;

  // Gated by reset so the pipeline hold also drops immediately on reset.
  assign stall_out = ms_riscv32_mp_rst_in &&
                     ((state != ST_IDLE) || (mem_req_in && !req_misaligned));

endmodule
